// File: rtl/frame_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_step_scheduler
// Brief    : Divides frames into game steps and runs MOVE/CHECK via req/ack in
//            vertical blanking. Optional macro FRAME_STEP_SPEEDUP_EN shortens
//            the period after every 8th step.
// Revision : 1.0 - initial release
// ============================================================================
module frame_step_scheduler #(
  parameter int VB_START_Y = 480,
  parameter int VB_START_X = 0,
  parameter int DEF_PERIOD = 8,
  parameter int MIN_PERIOD = 2
) (
  input  logic        VGA_clk,
  input  logic        reset,
  input  logic [9:0]  xCount,
  input  logic [9:0]  yCount,
  input  logic [3:0]  period_in,
  input  logic        period_load,
  input  logic        pause,
  input  logic        step_ack,
  input  logic        collision,
  output logic        step_req,
  output logic [1:0]  phase,
  output logic [15:0] frame_cnt,
  output logic [15:0] step_cnt,
  output logic        game_over,
  output logic        overrun
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_MOVE_REQ  = 2'd1;
  localparam logic [1:0] c_CHECK_REQ = 2'd2;
  localparam logic [1:0] c_HALT      = 2'd3;

  localparam logic [1:0] c_PH_NONE  = 2'd0;
  localparam logic [1:0] c_PH_MOVE  = 2'd1;
  localparam logic [1:0] c_PH_CHECK = 2'd2;

  localparam logic [3:0] c_DEF_PERIOD = 4'(DEF_PERIOD);
  localparam logic [3:0] c_MIN_PERIOD = 4'(MIN_PERIOD);

  logic       r_frameEvt;
  logic       r_blankEnd;
  logic [3:0] r_period;
  logic [3:0] r_div;
  logic [1:0] r_state;

  logic       w_divEnable;
  logic       w_stepDue;
  logic [3:0] w_periodClamped;
  logic [3:0] w_divAfterEvt;
  logic       w_checkAck;

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_frameEvt <= 1'b0;
      r_blankEnd <= 1'b0;
    end else begin
      r_frameEvt <= (xCount == 10'(VB_START_X)) && (yCount == 10'(VB_START_Y));
      r_blankEnd <= (xCount == 10'd0) && (yCount == 10'd0);
    end
  end

  assign w_divEnable     = r_frameEvt && !pause && !game_over;
  assign w_stepDue       = w_divEnable && (r_div == r_period - 4'd1);
  assign w_periodClamped = (period_in < c_MIN_PERIOD) ? c_MIN_PERIOD : period_in;
  assign w_divAfterEvt   = w_divEnable ? (w_stepDue ? 4'd0 : r_div + 4'd1) : r_div;
  assign w_checkAck      = (r_state == c_CHECK_REQ) && step_ack;

  // A same-cycle frame event was already judged against the old period above.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_div <= 4'd0;
    end else if (period_load && (w_divAfterEvt >= w_periodClamped)) begin
      r_div <= 4'd0;
    end else begin
      r_div <= w_divAfterEvt;
    end
  end

`ifdef FRAME_STEP_SPEEDUP_EN
  logic [3:0] w_periodDec;
  assign w_periodDec = (r_period > c_MIN_PERIOD) ? r_period - 4'd1 : c_MIN_PERIOD;

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_period <= c_DEF_PERIOD;
    end else if (period_load) begin
      r_period <= w_periodClamped;
    end else if (w_checkAck && (step_cnt[2:0] == 3'd7)) begin
      r_period <= w_periodDec;
    end
  end
`else
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_period <= c_DEF_PERIOD;
    end else if (period_load) begin
      r_period <= w_periodClamped;
    end
  end
`endif

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      step_req  <= 1'b0;
      phase     <= c_PH_NONE;
      frame_cnt <= 16'd0;
      step_cnt  <= 16'd0;
      game_over <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (r_frameEvt) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // A phase still pending at end of blank, or a step that cannot start.
      if ((r_blankEnd && ((r_state == c_MOVE_REQ) || (r_state == c_CHECK_REQ))) ||
          (w_stepDue && (r_state != c_IDLE))) begin
        overrun <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_stepDue) begin
            r_state  <= c_MOVE_REQ;
            step_req <= 1'b1;
            phase    <= c_PH_MOVE;
          end
        end
        c_MOVE_REQ: begin
          if (step_ack) begin
            r_state <= c_CHECK_REQ;
            phase   <= c_PH_CHECK;
          end
        end
        c_CHECK_REQ: begin
          if (step_ack) begin
            step_cnt <= step_cnt + 16'd1;
            step_req <= 1'b0;
            phase    <= c_PH_NONE;
            if (collision) begin
              game_over <= 1'b1;
              r_state   <= c_HALT;
            end else begin
              r_state <= c_IDLE;
            end
          end
        end
        c_HALT: begin
          step_req <= 1'b0;
          phase    <= c_PH_NONE;
        end
        default: begin
          r_state  <= c_IDLE;
          step_req <= 1'b0;
          phase    <= c_PH_NONE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_step_scheduler
// Brief    : Scoreboard bench for frame_step_scheduler on a compressed raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_step_scheduler;

  typedef struct {
    int ph;
    int fr;
    int sc;
    int lat;
  } rec_t;

  logic        VGA_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  xCount = 10'd1;
  logic [9:0]  yCount = 10'd1;
  logic [3:0]  period_in = 4'd0;
  logic        period_load = 1'b0;
  logic        pause = 1'b0;
  logic        step_ack = 1'b0;
  logic        collision = 1'b0;
  logic        step_req;
  logic [1:0]  phase;
  logic [15:0] frame_cnt;
  logic [15:0] step_cnt;
  logic        game_over;
  logic        overrun;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastMatchCyc = 0;
  int   tbFrames = 0;
  int   tbSteps = 0;
  bit   ackEn = 1'b1;
  bit   collideOnCheck = 1'b0;
  rec_t expQ[$];
  rec_t obsQ[$];

  frame_step_scheduler #(
    .VB_START_Y(480),
    .VB_START_X(0),
    .DEF_PERIOD(8),
    .MIN_PERIOD(2)
  ) dut (
    .VGA_clk(VGA_clk),
    .reset(reset),
    .xCount(xCount),
    .yCount(yCount),
    .period_in(period_in),
    .period_load(period_load),
    .pause(pause),
    .step_ack(step_ack),
    .collision(collision),
    .step_req(step_req),
    .phase(phase),
    .frame_cnt(frame_cnt),
    .step_cnt(step_cnt),
    .game_over(game_over),
    .overrun(overrun)
  );

  initial forever #5 VGA_clk = ~VGA_clk;
  initial forever begin @(posedge VGA_clk); cyc++; end

  // Game-logic model: acks each phase a couple of cycles after it starts.
  initial begin
    int cnt;
    logic [1:0] lastPh;
    cnt = 0;
    lastPh = 2'd0;
    forever begin
      @(negedge VGA_clk);
      step_ack = 1'b0;
      collision = 1'b0;
      if (reset || !step_req || phase !== lastPh) begin
        cnt = 0;
      end else if (ackEn && cnt >= 2) begin
        step_ack = 1'b1;
        collision = collideOnCheck && (phase == 2'd2);
        cnt = 0;
      end else begin
        cnt++;
      end
      lastPh = phase;
    end
  end

  // Records every phase change the DUT makes.
  initial begin
    logic [1:0] lastPh;
    rec_t r;
    lastPh = 2'd0;
    forever begin
      @(negedge VGA_clk);
      if (!reset && phase !== lastPh) begin
        r.ph  = int'(phase);
        r.fr  = int'(frame_cnt);
        r.sc  = int'(step_cnt);
        r.lat = (phase == 2'd1) ? cyc - lastMatchCyc : -1;
        obsQ.push_back(r);
      end
      lastPh = phase;
    end
  end

  // Compressed raster: rows 0..9 visible, rows 480..484 blank, 8 columns.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int r = 0; r < 15; r++) begin
        for (int x = 0; x < 8; x++) begin
          @(negedge VGA_clk);
          xCount = 10'(x);
          yCount = (r < 10) ? 10'(r) : 10'(470 + r);
          if (r == 10 && x == 0) begin
            tbFrames++;
            lastMatchCyc = cyc;
          end
        end
      end
    end
    @(negedge VGA_clk);
    xCount = 10'd1;
    yCount = 10'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge VGA_clk);
  endtask

  task automatic load_period(input logic [3:0] v);
    @(negedge VGA_clk);
    period_in = v;
    period_load = 1'b1;
    @(negedge VGA_clk);
    period_load = 1'b0;
  endtask

  task automatic push_step(input int fr);
    rec_t e;
    e.fr = fr; e.sc = tbSteps;
    e.ph = 1; e.lat = 2;  expQ.push_back(e);
    e.ph = 2; e.lat = -1; expQ.push_back(e);
    e.ph = 0; e.sc = tbSteps + 1; expQ.push_back(e);
    tbSteps++;
  endtask

  task automatic do_reset();
    @(negedge VGA_clk);
    reset = 1'b1;
    pause = 1'b0;
    ackEn = 1'b1;
    collideOnCheck = 1'b0;
    repeat (3) @(negedge VGA_clk);
    reset = 1'b0;
    expQ.delete();
    obsQ.delete();
    tbFrames = 0;
    tbSteps = 0;
    @(negedge VGA_clk);
  endtask

  task automatic test_reset(input string nm);
    do_reset();
    total += 6;
    if (step_req !== 1'b0)   begin bad++; $display("FAIL %s step_req got=%b want=0", nm, step_req); end
    if (phase !== 2'd0)      begin bad++; $display("FAIL %s phase got=%0d want=0", nm, phase); end
    if (frame_cnt !== 16'd0) begin bad++; $display("FAIL %s frame_cnt got=%0d want=0", nm, frame_cnt); end
    if (step_cnt !== 16'd0)  begin bad++; $display("FAIL %s step_cnt got=%0d want=0", nm, step_cnt); end
    if (game_over !== 1'b0)  begin bad++; $display("FAIL %s game_over got=%b want=0", nm, game_over); end
    if (overrun !== 1'b0)    begin bad++; $display("FAIL %s overrun got=%b want=0", nm, overrun); end
  endtask

  task automatic test_default_period();
    rec_t e, o;
    push_step(8);
    run_frames(8);
    total += 2;
    if (step_cnt !== 16'd1)  begin bad++; $display("FAIL first_step step_cnt got=%0d want=1", step_cnt); end
    if (frame_cnt !== 16'd8) begin bad++; $display("FAIL first_step frame_cnt got=%0d want=8", frame_cnt); end
    push_step(16);
    run_frames(8);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL default_period missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL default_period got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("FAIL default_period extra got=%0d want=0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_period_load();
    rec_t e, o;
    load_period(4'd0);          // clamps to 2
    push_step(18); push_step(20);
    run_frames(4);
    load_period(4'd15);
    push_step(35);
    run_frames(15);
    run_frames(5);              // divider now 5
    load_period(4'd3);          // divider clears
    push_step(43);
    run_frames(3);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL period_load missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL period_load got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("FAIL period_load extra got=%0d want=0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_pause();
    rec_t e, o;
    load_period(4'd8);
    run_frames(3);              // divider at 3
    pause = 1'b1;
    run_frames(5);
    total += 2;
    if (obsQ.size() != 0) begin bad++; $display("FAIL pause_hold records got=%0d want=0", obsQ.size()); obsQ.delete(); end
    if (frame_cnt !== 16'(tbFrames)) begin bad++; $display("FAIL pause_frames got=%0d want=%0d", frame_cnt, tbFrames); end
    pause = 1'b0;
    push_step(56);
    run_frames(5);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL pause_resume missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL pause_resume got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("FAIL pause_resume extra got=%0d want=0", obsQ.size()); obsQ.delete(); end
  endtask

  task automatic test_overrun();
    rec_t e, o;
    load_period(4'd2);
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre got=%b want=0", overrun); end
    ackEn = 1'b0;
    e.ph = 1; e.fr = 58; e.sc = tbSteps; e.lat = 2;  expQ.push_back(e);
    e.ph = 2; e.fr = 59; e.lat = -1;                 expQ.push_back(e);
    e.ph = 0; e.sc = tbSteps + 1;                    expQ.push_back(e);
    tbSteps++;
    run_frames(2);
    total += 2;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early got=%b want=0", overrun); end
    if (phase !== 2'd1)   begin bad++; $display("FAIL overrun_wait phase got=%0d want=1", phase); end
    run_frames(1);              // blank end passes with MOVE pending
    total += 2;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
    if (phase !== 2'd1)   begin bad++; $display("FAIL overrun_noabort phase got=%0d want=1", phase); end
    ackEn = 1'b1;
    idle(12);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL overrun_late_ack missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL overrun_late_ack got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total += 2;
    if (obsQ.size() != 0) begin bad++; $display("FAIL overrun_late_ack extra got=%0d want=0", obsQ.size()); obsQ.delete(); end
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_collision();
    rec_t e, o;
    collideOnCheck = 1'b1;
    push_step(60);
    run_frames(1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL collision missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL collision got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total++;
    if (game_over !== 1'b1) begin bad++; $display("FAIL game_over_set got=%b want=1", game_over); end
    run_frames(20);
    total += 3;
    if (obsQ.size() != 0)    begin bad++; $display("FAIL halt_quiet records got=%0d want=0", obsQ.size()); obsQ.delete(); end
    if (step_req !== 1'b0)   begin bad++; $display("FAIL halt_req got=%b want=0", step_req); end
    if (frame_cnt !== 16'd80) begin bad++; $display("FAIL halt_frames got=%0d want=80", frame_cnt); end
  endtask

  task automatic test_speedup();
    rec_t e, o;
    int p, fr;
    p = 8;
    fr = 0;
    for (int k = 1; k <= 9; k++) begin
      fr += p;
      push_step(fr);
`ifdef FRAME_STEP_SPEEDUP_EN
      if (k % 8 == 0 && p > 2) p--;
`endif
    end
    run_frames(72);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (obsQ.size() == 0) begin
        bad++; $display("FAIL speedup missing got=none want ph=%0d fr=%0d sc=%0d", e.ph, e.fr, e.sc);
      end else begin
        o = obsQ.pop_front();
        if (o.ph !== e.ph || o.fr !== e.fr || o.sc !== e.sc || (e.lat >= 0 && o.lat !== e.lat)) begin
          bad++; $display("FAIL speedup got ph=%0d fr=%0d sc=%0d lat=%0d want ph=%0d fr=%0d sc=%0d lat=%0d",
                          o.ph, o.fr, o.sc, o.lat, e.ph, e.fr, e.sc, e.lat);
        end
      end
    end
    total++;
    if (obsQ.size() != 0) begin bad++; $display("FAIL speedup extra got=%0d want=0", obsQ.size()); obsQ.delete(); end
  endtask

  initial begin
    test_reset("reset_initial");
    test_default_period();
    test_period_load();
    test_pause();
    test_overrun();
    test_collision();
    test_reset("reset_after_halt");
    test_speedup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
